// File: rtl/frame_receiver.sv
// frame_receiver: oversampled serial frame decoder (start, length, data, CRC-8, stop) feeding a byte FIFO.
// Define FRAME_RX_CRC_EN to carry and check a CRC-8 field between the data and the stop bit.
module frame_receiver #(
  parameter int DIV_W      = 8,
  parameter int LEN_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int NOISE_TOL  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx,
  input  logic [DIV_W-1:0] baudrate,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done,
  output logic             nf,
  output logic             crce,
  output logic             fe,
  output logic             over,
  output logic             busy
);
  localparam int CW    = DIV_W + 1;
  localparam int BMAX  = (LEN_W > 8) ? LEN_W : 8;
  localparam int BC_W  = $clog2(BMAX);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, START, LEN, DATA, CRC, STOP} state_t;
`ifdef FRAME_RX_CRC_EN
  localparam state_t AFTER_DATA = CRC;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t           state;
  logic [CW-1:0]    cnt, ones, zeros, ones_n, zeros_n, minority, baud_eff;
  logic [DIV_W-1:0] baud_q;
  logic             dec, bit_val, noisy;
  logic [BC_W-1:0]  bitc;
  logic [LEN_W-1:0] bytec, len_q;
  logic [6:0]       sh;
  logic             over_acc;

  logic [8:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fcount;
  logic             push_req, push_ok, push_drop, pop, full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // In IDLE the counters sit at zero, so the start-detect clock is sample 0 of the START period.
  always_comb begin
    ones_n   = ones + CW'(rx);
    zeros_n  = zeros + CW'(!rx);
    bit_val  = ones_n > zeros_n;
    minority = (ones_n < zeros_n) ? ones_n : zeros_n;
    noisy    = minority > CW'(NOISE_TOL);
    baud_eff = (state == IDLE) ? CW'(baudrate) : CW'(baud_q);
    dec      = ((state != IDLE) || rx) && (cnt == baud_eff);
    push_req = (state == DATA) && dec && !noisy && (bitc == BC_W'(7));
    pop      = out_valid && out_ready;
    full     = fcount == CNT_W'(FIFO_DEPTH);
    push_ok  = push_req && (!full || pop);
    push_drop = push_req && full && !pop;
  end

  assign out_valid = fcount != '0;
  assign out_data  = out_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign out_last  = out_valid && mem[rd_ptr][8];
  assign busy      = state != IDLE;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {bytec == len_q, sh, bit_val};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcount <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push_ok && !pop) fcount <= fcount + CNT_W'(1);
      else if (pop && !push_ok) fcount <= fcount - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && rx) baud_q <= baudrate;
    if (dec && state == LEN) len_q <= LEN_W'({len_q, bit_val});
    if (dec && (state == DATA || state == CRC)) sh <= {sh[5:0], bit_val};
  end

`ifdef FRAME_RX_CRC_EN
  logic [7:0] crc;
  logic       crce_acc;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  always_ff @(posedge clk) begin
    if (state == IDLE && rx) crc <= 8'h00;
    else if (dec && (state == LEN || state == DATA)) crc <= crc8_step(crc, bit_val);
  end
`else
  assign crce = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ones     <= '0;
      zeros    <= '0;
      bitc     <= '0;
      bytec    <= '0;
      over_acc <= 1'b0;
      done     <= 1'b0;
      nf       <= 1'b0;
      fe       <= 1'b0;
      over     <= 1'b0;
`ifdef FRAME_RX_CRC_EN
      crce     <= 1'b0;
      crce_acc <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (push_drop) over_acc <= 1'b1;
      if (dec || (state == IDLE && !rx)) begin
        cnt   <= '0;
        ones  <= '0;
        zeros <= '0;
      end else begin
        cnt   <= cnt + CW'(1);
        ones  <= ones_n;
        zeros <= zeros_n;
      end
      if (dec && noisy && state != IDLE && state != START) begin
        state <= IDLE;
        done  <= 1'b1;
        nf    <= 1'b1;
        fe    <= 1'b0;
        over  <= over_acc;
`ifdef FRAME_RX_CRC_EN
        crce  <= 1'b0;
`endif
      end else begin
        case (state)
          // A zero divisor decides the start bit on the detect clock itself.
          IDLE: if (rx) begin
            over_acc <= 1'b0;
            bitc     <= '0;
`ifdef FRAME_RX_CRC_EN
            crce_acc <= 1'b0;
`endif
            state    <= dec ? LEN : START;
          end
          START: if (dec) begin
            bitc  <= '0;
            state <= (bit_val && !noisy) ? LEN : IDLE;
          end
          LEN: if (dec) begin
            if (bitc == BC_W'(LEN_W - 1)) begin
              bitc  <= '0;
              bytec <= '0;
              state <= DATA;
            end else bitc <= bitc + BC_W'(1);
          end
          DATA: if (dec) begin
            if (bitc == BC_W'(7)) begin
              bitc <= '0;
              if (bytec == len_q) state <= AFTER_DATA;
              else bytec <= bytec + LEN_W'(1);
            end else bitc <= bitc + BC_W'(1);
          end
`ifdef FRAME_RX_CRC_EN
          CRC: if (dec) begin
            if (bitc == BC_W'(7)) begin
              crce_acc <= {sh, bit_val} != crc;
              state    <= STOP;
            end else bitc <= bitc + BC_W'(1);
          end
`endif
          STOP: if (dec) begin
            state <= IDLE;
            done  <= 1'b1;
            nf    <= 1'b0;
            fe    <= bit_val;
            over  <= over_acc;
`ifdef FRAME_RX_CRC_EN
            crce  <= crce_acc;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
